// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and default widths for the shift-and-add multiplier
//
// Purpose : state encoding and default operand widths used by seq_multiplier.
// Contents: MCAND_W_DEF / MPLR_W_DEF default operand widths, CNT_W_DEF bit counter
//           width, state_t FSM encoding {IDLE, BUSY, DONE}.
package mult_pkg;

  localparam int MCAND_W_DEF = 4;
  localparam int MPLR_W_DEF  = 3;
  // Counter must reach MPLR_W itself (the extra write-back cycle), hence +1.
  localparam int CNT_W_DEF   = $clog2(MPLR_W_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - sequential shift-and-add unsigned multiplier, one multiplier bit per clock
//
// Purpose : multiplies an unsigned MCAND_W-bit multiplicand by an unsigned MPLR_W-bit
//           multiplier, producing a PROD_W-bit product. Started by a level-sensitive
//           en; done/product are registered and product only changes on completion.
// Ports   : clk          rising-edge clock
//           rst_n        asynchronous active-low reset
//           multiplier   multiplier operand, sampled on the start edge
//           multiplicand multiplicand operand, sampled on the start edge
//           en           start request (honoured in IDLE and DONE, ignored in BUSY)
//           done         result valid, held high in DONE
//           product      last completed product
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int MCAND_W = MCAND_W_DEF,
  parameter int MPLR_W  = MPLR_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [MPLR_W-1:0]          multiplier,
  input  logic [MCAND_W-1:0]         multiplicand,
  input  logic                       en,
  output logic                       done,
  output logic [MCAND_W+MPLR_W-1:0]  product
);

  localparam int PROD_W = MCAND_W + MPLR_W;
  localparam int CNT_W  = $clog2(MPLR_W + 1);

  state_t             r_state;
  state_t             w_next_state;
  logic               w_start;
  logic               w_finish;

  logic [MCAND_W-1:0] r_mcand;
  logic [MPLR_W-1:0]  r_mplr;
  logic [PROD_W-1:0]  r_acc;
  logic [CNT_W-1:0]   r_count;
  logic [PROD_W-1:0]  r_product;
  logic               r_done;
  logic [PROD_W-1:0]  w_addend;

  // Multiplicand weighted by the position of the multiplier bit being consumed.
  assign w_addend = {{MPLR_W{1'b0}}, r_mcand} << r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_start      = 1'b1;
          w_next_state = BUSY;
        end
      end
      BUSY: begin
        // All MPLR_W bits have been accumulated; this edge publishes the result.
        if (r_count == CNT_W'(MPLR_W)) begin
          w_finish     = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (en) begin
          w_start      = 1'b1;
          w_next_state = BUSY;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else if (w_start) begin
      r_mcand <= multiplicand;
      r_mplr  <= multiplier;
      r_acc   <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else if (w_finish) begin
      r_product <= r_acc;
      r_done    <= 1'b1;
    end else if (r_state == BUSY) begin
      if (r_mplr[0]) begin
        r_acc <= r_acc + w_addend;
      end
      r_mplr  <= r_mplr >> 1;
      r_count <= r_count + 1'b1;
    end
  end

  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - scoreboard bench for seq_multiplier
module tb_seq_multiplier;

  localparam int LATENCY = 4;
  localparam int TIMEOUT = 12;

  logic       clk;
  logic       rst_n;
  logic [2:0] multiplier;
  logic [3:0] multiplicand;
  logic       en;
  logic       done;
  logic [6:0] product;

  int n_checks;
  int n_errors;
  int cyc;
  int t_start;
  int exp_q[$];

  seq_multiplier dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .en           (en),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one start request on the next cycle; leaves en high when keep_en is set.
  task automatic start_op(input int mplr, input int mcand, input bit keep_en);
    @(negedge clk);
    en           = 1'b1;
    multiplier   = 3'(mplr);
    multiplicand = 4'(mcand);
    exp_q.push_back(mplr * mcand);
    @(posedge clk);
    #1;
    t_start = cyc;
    if (!keep_en) en = 1'b0;
  endtask

  // Waits for done, then pops the scoreboard and checks value and latency.
  task automatic wait_result(input string tag);
    bit seen;
    int exp;
    seen = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq({tag, "_seen"}, int'(seen), 1);
    if (seen) begin
      if (exp_q.size() == 0) begin
        check_eq({tag, "_sb_nonempty"}, 0, 1);
      end else begin
        exp = exp_q.pop_front();
        check_eq({tag, "_product"}, int'(product), exp);
        check_eq({tag, "_latency"}, cyc - t_start, LATENCY);
      end
    end
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    cyc          = 0;
    t_start      = 0;
    rst_n        = 1'b0;
    en           = 1'b1;
    multiplier   = 3'd7;
    multiplicand = 4'd15;

    // Reset held with en high: nothing may start.
    repeat (3) @(negedge clk);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_product", int'(product), 0);
    rst_n = 1'b1;
    en    = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("idle_done", int'(done), 0);
    check_eq("idle_product", int'(product), 0);

    // 1 x 15 with a single-cycle en pulse, result must hold afterwards.
    start_op(1, 15, 1'b0);
    wait_result("op1x15");
    repeat (3) @(negedge clk);
    check_eq("hold_done", int'(done), 1);
    check_eq("hold_product", int'(product), 15);

    // en re-asserted with new operands while BUSY: running op unaffected.
    start_op(1, 15, 1'b0);
    en           = 1'b1;
    multiplier   = 3'd7;
    multiplicand = 4'd15;
    check_eq("busy_done_low", int'(done), 0);
    wait_result("busy_en");
    exp_q.push_back(105);
    @(posedge clk);
    #1;
    t_start = cyc;
    en = 1'b0;
    check_eq("restart_done_low", int'(done), 0);
    wait_result("from_done");

    // Back-to-back operations with en held high.
    start_op(7, 15, 1'b1);
    for (int k = 0; k < 3; k++) begin
      wait_result("b2b");
      if (k < 2) begin
        exp_q.push_back(105);
        @(posedge clk);
        #1;
        t_start = cyc;
        check_eq("b2b_done_low", int'(done), 0);
      end else begin
        en = 1'b0;
      end
    end

    // Corner operands; latency must not depend on values.
    start_op(0, 15, 1'b0);
    wait_result("op0x15");
    start_op(7, 0, 1'b0);
    wait_result("op7x0");
    start_op(5, 9, 1'b0);
    wait_result("op5x9");

    // Asynchronous reset in the middle of an operation.
    start_op(3, 5, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_done", int'(done), 0);
    check_eq("arst_product", int'(product), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("arst_idle_done", int'(done), 0);
    check_eq("arst_idle_product", int'(product), 0);

    // Recovery after the aborted operation.
    start_op(2, 3, 1'b0);
    wait_result("op2x3");

    check_eq("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
